uart_rx_deserializer: RTL and testbench

//   Receives 8-bit asynchronous serial frames on a single idle-high line and presents each byte on a

---
 rtl/uart_rx_deserializer.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronizes rx, samples each bit at mid-bit and presents bytes with pulse status.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx_deserializer #(
    parameter logic [15:0] CLKS_PER_BIT = 16'd10408,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [15:0] HALF_RELOAD = (CLKS_PER_BIT >> 1) - 16'd1;
    localparam logic [15:0] FULL_RELOAD = CLKS_PER_BIT - 16'd1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [15:0]            baud_cnt, baud_next;
    logic [2:0]             bit_cnt, bit_next;
    logic [7:0]             shreg, shreg_next;
    logic [7:0]             data_next;
    logic                   valid_next;
    logic                   ferr_next;
    logic                   tick;
    logic                   parity_bad;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_next;
    logic perr_next;
    assign parity_bad = (^shreg) ^ par_q;
`else
    assign parity_bad = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Idle-high line: synchronizer flops reset to 1 so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign tick = (baud_cnt == 16'd0) && (state != IDLE);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shreg     <= shreg_next;
            rx_data   <= data_next;
            rx_valid  <= valid_next;
            frame_err <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_next;
            parity_err <= perr_next;
`endif
        end
    end

    // The first reload is half a bit so every later full-bit reload lands at mid-bit.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        data_next  = rx_data;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next   = par_q;
        perr_next  = 1'b0;
`endif
        if ((state != IDLE) && (baud_cnt != 16'd0)) begin
            baud_next = baud_cnt - 16'd1;
        end

        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                    baud_next  = HALF_RELOAD;
                end
            end
            START: begin
                if (tick) begin
                    if (!rxs) begin
                        state_next = DATA;
                        baud_next  = FULL_RELOAD;
                        bit_next   = 3'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_next = {rxs, shreg[7:1]};
                    bit_next   = bit_cnt + 3'd1;
                    baud_next  = FULL_RELOAD;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_next   = rxs;
                    baud_next  = FULL_RELOAD;
                    state_next = STOP;
                end
            end
`endif
            // A bad parity byte is dropped but still returns to IDLE if the stop bit is good.
            STOP: begin
                if (tick) begin
                    if (rxs) begin
                        state_next = IDLE;
                        if (!parity_bad) begin
                            data_next  = shreg;
                            valid_next = 1'b1;
                        end
                    end else begin
                        state_next = BREAK;
                        ferr_next  = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    perr_next = parity_bad;
`endif
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: table of whole frames plus hand-written
// latency, glitch, break, back-to-back and mid-frame reset sequences.
module tb_uart_rx_deserializer;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_flip;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int both_cnt = 0;
    logic [7:0] got_bytes[$];

    vec_t       vecs[$];
    logic [7:0] model_data;
    int         v0, f0, p0, b0, q0;
    int         lat_n;
    bit         lat_seen;

    uart_rx_deserializer #(
        .CLKS_PER_BIT(16'd16),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                valid_cnt++;
                got_bytes.push_back(rx_data);
            end
            if (frame_err) ferr_cnt++;
            if (parity_err) perr_cnt++;
            if (frame_err && parity_err) both_cnt++;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snapshot();
        v0 = valid_cnt;
        f0 = ferr_cnt;
        p0 = perr_cnt;
        b0 = both_cnt;
        q0 = got_bytes.size();
    endtask

    // Start, data LSB-first and (when built in) the even-parity bit; caller sits at a negedge.
    task automatic send_bits(input logic [7:0] data, input logic par_flip);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            idle(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^data) ^ par_flip;
        idle(CPB);
`else
        if (par_flip) $display("[TB] parity flip ignored in this build");
`endif
    endtask

    task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit, input logic par_flip);
        send_bits(data, par_flip);
        rx = stop_bit;
        idle(CPB);
        rx = 1'b1;
    endtask

    task automatic wait_not_busy(input string name, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output(name, busy, 1'b0);
    endtask

    initial begin
        vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF});
        vecs.push_back('{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A});
        vecs.push_back('{8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h81});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81});
        vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h07});
        vecs.push_back('{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07});
`endif

        rst = 1'b1;
        rx  = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(2);
        check_output("reset rx_data", rx_data, 8'h00);
        check_output("reset rx_valid", rx_valid, 1'b0);
        check_output("reset frame_err", frame_err, 1'b0);
        check_output("reset parity_err", parity_err, 1'b0);
        check_output("reset busy", busy, 1'b0);

        // Latency counts edges after the first edge that samples the low line.
        snapshot();
        lat_n    = 0;
        lat_seen = 1'b0;
        fork
            apply_stimulus(8'hA5, 1'b1, 1'b0);
            begin
                while (!lat_seen && lat_n < 400) begin
                    @(posedge clk);
                    lat_n++;
                    #1;
                    if (rx_valid) lat_seen = 1'b1;
                end
            end
        join
        idle(4);
        check_output("latency seen", lat_seen, 1'b1);
        check_output("latency", lat_n - 1, SYNC + CPB / 2 + 9 * CPB + PAR_BITS * CPB);
        check_output("A5 valid count", valid_cnt - v0, 1);
        check_output("A5 rx_data", rx_data, 8'hA5);
        check_output("A5 frame_err", ferr_cnt - f0, 0);
        model_data = 8'hA5;

        foreach (vecs[k]) begin
            snapshot();
            apply_stimulus(vecs[k].data, vecs[k].stop_bit, vecs[k].par_flip);
            idle(20);
            check_output($sformatf("vec%0d valid", k), valid_cnt - v0, 32'(vecs[k].exp_valid));
            check_output($sformatf("vec%0d frame_err", k), ferr_cnt - f0, 32'(vecs[k].exp_ferr));
            check_output($sformatf("vec%0d parity_err", k), perr_cnt - p0, 32'(vecs[k].exp_perr));
            check_output($sformatf("vec%0d same-cycle errs", k), both_cnt - b0,
                         32'(vecs[k].exp_ferr && vecs[k].exp_perr));
            check_output($sformatf("vec%0d rx_data", k), rx_data, vecs[k].exp_data);
            check_output($sformatf("vec%0d busy", k), busy, 1'b0);
            model_data = vecs[k].exp_data;
        end

        snapshot();
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        wait_not_busy("glitch busy", 10);
        idle(30);
        check_output("glitch valid", valid_cnt - v0, 0);
        check_output("glitch frame_err", ferr_cnt - f0, 0);

        // Held-low line after a bad stop bit: one frame_err, then parked until the line rises.
        snapshot();
        send_bits(8'h3C, 1'b0);
        rx = 1'b0;
        idle(CPB + 100);
        check_output("break frame_err", ferr_cnt - f0, 1);
        check_output("break busy", busy, 1'b1);
        check_output("break rx_data", rx_data, model_data);
        check_output("break valid", valid_cnt - v0, 0);
        rx = 1'b1;
        wait_not_busy("break release busy", 10);
        idle(10);
        check_output("break frame_err after release", ferr_cnt - f0, 1);

        snapshot();
        apply_stimulus(8'h01, 1'b1, 1'b0);
        apply_stimulus(8'hFF, 1'b1, 1'b0);
        apply_stimulus(8'h80, 1'b1, 1'b0);
        idle(20);
        check_output("b2b valid count", valid_cnt - v0, 3);
        if (got_bytes.size() >= q0 + 3) begin
            check_output("b2b byte0", got_bytes[q0], 8'h01);
            check_output("b2b byte1", got_bytes[q0 + 1], 8'hFF);
            check_output("b2b byte2", got_bytes[q0 + 2], 8'h80);
        end
        check_output("b2b frame_err", ferr_cnt - f0, 0);

        snapshot();
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            idle(CPB);
        end
        rx = 1'b1;
        idle(CPB / 2);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);
        check_output("midreset rx_data", rx_data, 8'h00);
        check_output("midreset busy", busy, 1'b0);
        idle(20);
        check_output("midreset no strobe", valid_cnt - v0, 0);
        apply_stimulus(8'hC3, 1'b1, 1'b0);
        idle(20);
        check_output("after reset valid", valid_cnt - v0, 1);
        check_output("after reset rx_data", rx_data, 8'hC3);
        check_output("after reset frame_err", ferr_cnt - f0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
